uart_rx_ip: RTL and testbench

- Memory-mapped UART receiver peripheral on the SoC local bus. It is the receive-side counterpart to uart_ip's transmitter.
- Samples the asynchronous serial line, deframes 8N1 bytes, and buffers them in an RX FIFO.
- Exposes data, status and baud-divisor registers to FemtoRV32 through the same local-bus signalling as gpio_ip and uart_ip.
- Selected by device_select; the top level gates wen/ren with the select line.

---
 rtl/uart_rx_ip.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_ip.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ip.sv
// Memory-mapped 8N1 UART receiver with RX FIFO, sticky error flags and a programmable baud divisor.
// Optional parity check is compiled in with `define UART_RX_PARITY_EN (BAUD bit16 selects odd parity).
module uart_rx_ip #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    output logic        wready,
    input  logic [31:0] raddr,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        i_uart_rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t           state_q;
    logic             rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0] cnt_q, act_div_q, div_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             par_bad_q;
    logic             odd_q;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             overrun_q, frame_err_q, parity_err_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, wready_q;

    logic stop_done_s, push_req_s, push_s, pop_s, frame_set_s, par_set_s, overrun_set_s;
    logic full_s, empty_s, status_wr_s, baud_wr_s;
    logic unused_s;

    assign unused_s = &{1'b0, waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0],
                        wdata[31:CNT_W], wstrb[3:1]};

    assign full_s        = (count_q == CW'(FIFO_DEPTH));
    assign empty_s       = (count_q == '0);
    assign stop_done_s   = (state_q == ST_STOP) && (cnt_q == '0);
    assign push_req_s    = stop_done_s && rx_sync_q && !par_bad_q;
    assign frame_set_s   = stop_done_s && !rx_sync_q;
    assign pop_s         = ren && (raddr[3:2] == 2'd0) && !empty_s;
    // A full FIFO still accepts the byte when a read frees a slot in the same cycle.
    assign push_s        = push_req_s && (!full_s || pop_s);
    assign overrun_set_s = push_req_s && full_s && !pop_s;
    assign status_wr_s   = wen && wstrb[0] && (waddr[3:2] == 2'd1);
    assign baud_wr_s     = wen && wstrb[0] && (waddr[3:2] == 2'd2);

`ifdef UART_RX_PARITY_EN
    assign par_set_s = (state_q == ST_PARITY) && (cnt_q == '0) &&
                       ((^shift_q ^ rx_sync_q) != odd_q);
`else
    assign par_set_s = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receive FSM: bit timing, deframing and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            act_div_q <= CNT_W'(CLKS_PER_BIT);
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            par_bad_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    par_bad_q <= 1'b0;
                    if (!rx_sync_q) begin
                        act_div_q <= div_q;
                        cnt_q     <= div_q >> 1;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (rx_sync_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q     <= act_div_q - CNT_W'(1);
                        bit_idx_q <= 3'd0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        cnt_q     <= act_div_q - CNT_W'(1);
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
                ST_PARITY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        par_bad_q <= par_set_s;
                        cnt_q     <= act_div_q - CNT_W'(1);
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO storage (no reset needed; validity is tracked by count_q)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_s) wptr_q <= wptr_q + AW'(1);
            if (pop_s)  rptr_q <= rptr_q + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky flags (a same-cycle set wins over W1C) and baud divisor register
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            div_q        <= CNT_W'(CLKS_PER_BIT);
            odd_q        <= 1'b0;
        end else begin
            overrun_q    <= overrun_set_s | (overrun_q    & ~(status_wr_s & wdata[1]));
            frame_err_q  <= frame_set_s   | (frame_err_q  & ~(status_wr_s & wdata[2]));
            parity_err_q <= par_set_s     | (parity_err_q & ~(status_wr_s & wdata[4]));
            if (baud_wr_s) begin
                div_q <= (wdata[CNT_W-1:0] < CNT_W'(4)) ? CNT_W'(4) : wdata[CNT_W-1:0];
`ifdef UART_RX_PARITY_EN
                odd_q <= wdata[16];
`endif
            end
        end
    end

    // Read mux over pre-write state
    always_comb begin
        rdata_d = 32'h0000_0000;
        case (raddr[3:2])
            2'd0: begin
                if (!empty_s) begin
                    rdata_d = {24'h000000, mem_q[rptr_q]};
                end else begin
                    rdata_d = 32'h0000_0000;
                end
            end
            2'd1: rdata_d = {16'h0000, 8'(count_q), 3'b000, parity_err_q, full_s,
                             frame_err_q, overrun_q, !empty_s};
            2'd2: begin
                rdata_d[CNT_W-1:0] = div_q;
`ifdef UART_RX_PARITY_EN
                rdata_d[16] = odd_q;
`endif
            end
            default: rdata_d = 32'h0000_0000;
        endcase
    end

    // Registered bus responses
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= 32'h0000_0000;
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
        end else begin
            rvalid_q <= ren;
            wready_q <= wen;
            if (ren) rdata_q <= rdata_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign wready = wready_q;

endmodule

// File: tb/tb_uart_rx_ip.sv
// Directed self-checking bench for uart_rx_ip; define UART_RX_PARITY_EN to also cover parity.
module tb_uart_rx_ip;
    localparam int CPB = 868;
    localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_BAUD = 32'h8, A_RSVD = 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] waddr, wdata, raddr, rdata;
    logic        wen, ren, wready, rvalid, rx;
    logic [3:0]  wstrb;
    logic [31:0] rd;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    uart_rx_ip dut (
        .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb),
        .wready(wready), .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
        .i_uart_rx(rx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        waddr = a; wdata = d; wstrb = 4'hF; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        check("wready_pulse", {31'b0, wready}, 32'd1);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        raddr = a; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        check("rvalid_pulse", {31'b0, rvalid}, 32'd1);
        d = rdata;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_en,
                              input logic par, input int div);
        rx = 1'b0; idle(div);
        for (int i = 0; i < 8; i++) begin
            rx = d[i]; idle(div);
        end
        if (par_en) begin
            rx = par; idle(div);
        end
        rx = stop; idle(div);
        rx = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; wen = 1'b0; ren = 1'b0;
        waddr = '0; wdata = '0; raddr = '0; wstrb = 4'h0;
        idle(3);
        rst = 1'b0;
        check("reset_wready", {31'b0, wready}, 32'd0);
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        idle(1);
        check("rvalid_idle", {31'b0, rvalid}, 32'd0);
        read_check("reset_status", A_STAT, 32'h0);
        read_check("reset_baud", A_BAUD, 32'd868);
        read_check("empty_rxdata", A_DATA, 32'h0);

        // Test 1: single byte at divisor 16, plus BAUD clamp and reserved register
        bus_write(A_BAUD, 32'd2);
        read_check("baud_clamp", A_BAUD, 32'd4);
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        read_check("reserved", A_RSVD, 32'h0);
        bus_write(A_BAUD, 32'd16);
        read_check("baud16", A_BAUD, 32'd16);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 16);
        idle(4);
        read_check("t1_status", A_STAT, 32'h0000_0101);
        read_check("t1_data", A_DATA, 32'hA5);
        read_check("t1_status_after", A_STAT, 32'h0);

        // Test 2: nine back-to-back frames into an 8-deep FIFO
        for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0, 16);
        idle(20);
        read_check("t2_status_full", A_STAT, 32'h0000_080B);
        for (int b = 1; b <= 8; b++) read_check("t2_data", A_DATA, 32'(b));
        read_check("t2_data_empty", A_DATA, 32'h0);
        read_check("t2_status_ovr", A_STAT, 32'h0000_0002);
        bus_write(A_STAT, 32'h2);
        read_check("t2_status_clr", A_STAT, 32'h0);

        // Test 3: framing error then a good frame
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16);
        idle(48);
        read_check("t3_status_ferr", A_STAT, 32'h0000_0004);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 16);
        idle(4);
        read_check("t3_status_good", A_STAT, 32'h0000_0105);
        read_check("t3_data", A_DATA, 32'h55);
        bus_write(A_STAT, 32'h4);
        read_check("t3_status_clr", A_STAT, 32'h0);

        // Test 4: short glitch on an idle line
        rx = 1'b0; idle(4); rx = 1'b1;
        idle(40);
        read_check("t4_status_glitch", A_STAT, 32'h0);

        // Test 5: reset mid-frame with a byte already queued
        send_frame(8'h66, 1'b1, 1'b0, 1'b0, 16);
        idle(4);
        read_check("t5_status_pre", A_STAT, 32'h0000_0101);
        rx = 1'b0; idle(16);
        rx = 1'b1; idle(16);
        rx = 1'b1; idle(16);
        rx = 1'b1; idle(8);
        rst = 1'b1; idle(1); rst = 1'b0; rx = 1'b1;
        idle(40);
        read_check("t5_status_rst", A_STAT, 32'h0);
        read_check("t5_baud_rst", A_BAUD, 32'd868);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, CPB);
        idle(8);
        read_check("t5_status_new", A_STAT, 32'h0000_0101);
        read_check("t5_data", A_DATA, 32'h12);

`ifdef UART_RX_PARITY_EN
        // Test 6: even and odd parity
        bus_write(A_BAUD, 32'd16);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 16);
        idle(4);
        read_check("t6_status_perr", A_STAT, 32'h0000_0010);
        bus_write(A_STAT, 32'h10);
        read_check("t6_status_clr", A_STAT, 32'h0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 16);
        idle(4);
        read_check("t6_status_even_ok", A_STAT, 32'h0000_0101);
        read_check("t6_data_even", A_DATA, 32'h03);
        bus_write(A_BAUD, 32'h0001_0010);
        read_check("t6_baud_odd", A_BAUD, 32'h0001_0010);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 16);
        idle(4);
        read_check("t6_status_odd_ok", A_STAT, 32'h0000_0101);
        read_check("t6_data_odd", A_DATA, 32'h03);
`else
        // Without parity support BAUD bit16 is not writable
        bus_write(A_BAUD, 32'h0001_0010);
        read_check("baud_bit16_ro", A_BAUD, 32'h0000_0010);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
